// File: rtl/mips_trace_pkg.sv
// Shared trace-entry layout and kind encodings for the MIPS commit-trace buffer.
package mips_trace_pkg;

    localparam int TRACE_W    = 64;
    localparam int KIND_LSB   = 62;
    localparam int KIND_W     = 2;
    localparam int STAMP_LSB  = 48;
    localparam int STAMP_W    = 14;
    localparam int TAG_LSB    = 32;
    localparam int TAG_W      = 16;
    localparam int VALUE_LSB  = 0;
    localparam int VALUE_W    = 32;
    localparam int DROP_CNT_W = 16;

    typedef enum logic [KIND_W-1:0] {
        TRACE_KIND_NONE = 2'b00,
        TRACE_KIND_REG  = 2'b01,
        TRACE_KIND_MEM  = 2'b10,
        TRACE_KIND_DROP = 2'b11
    } trace_kind_e;

    typedef struct packed {
        trace_kind_e          kind;
        logic [STAMP_W-1:0]   stamp;
        logic [TAG_W-1:0]     tag;
        logic [VALUE_W-1:0]   value;
    } trace_entry_t;

endpackage

// File: rtl/mips_trace_buffer_if.sv
// Event inputs and drain stream of the trace buffer; slave = buffer side, master = core/host side.
interface mips_trace_buffer_if #(parameter int DEPTH = 16);
    import mips_trace_pkg::*;

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic               trace_en;
    logic               reg_write;
    logic [4:0]         write_reg;
    logic [31:0]        write_data;
    logic               mem_write;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic               out_valid;
    logic               out_ready;
    logic [TRACE_W-1:0] out_data;
    logic [LVL_W-1:0]   fifo_level;
    logic               overflow_seen;

    modport master (
        output trace_en, reg_write, write_reg, write_data,
        output mem_write, mem_addr, mem_wdata, out_ready,
        input  out_valid, out_data, fifo_level, overflow_seen
    );

    modport slave (
        input  trace_en, reg_write, write_reg, write_data,
        input  mem_write, mem_addr, mem_wdata, out_ready,
        output out_valid, out_data, fifo_level, overflow_seen
    );

endinterface

// File: rtl/mips_trace_buffer_fifo.sv
// First-word-fall-through synchronous FIFO; head reads as zero while empty.
module trace_fifo
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = TRACE_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output logic         o_valid,
    output logic         o_full,
    output logic [LW-1:0] o_level
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_pop;
    logic          w_push;

    assign o_valid = (r_level != '0);
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_level = r_level;
    assign o_rdata = o_valid ? r_mem[r_rd_ptr] : '0;
    assign w_pop   = i_pop & o_valid;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    // Storage carries no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/mips_trace_buffer.sv
// Commit-trace capture: decodes core writebacks/stores into stamped entries with overflow markers.
// Define TRACE_MEM_ENABLE_EN to also capture data-memory stores.
module mips_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    mips_trace_buffer_if.slave bus
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] a,
                                                      input logic [1:0] b);
        logic [DROP_CNT_W:0] s;
        s = {1'b0, a} + {{(DROP_CNT_W-1){1'b0}}, b};
        return s[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : s[DROP_CNT_W-1:0];
    endfunction

    logic [STAMP_W-1:0]    r_cycle;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic                  r_marker_pending;
    logic                  r_overflow_seen;

    logic                  w_reg_evt;
    logic                  w_mem_evt;
    logic [1:0]            w_evt_n;
    logic                  w_valid;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_free;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_marker_nxt;
    logic [DROP_CNT_W-1:0] w_drop_cnt_nxt;
    trace_entry_t          w_entry;
    logic                  w_unused_mem;

    assign w_reg_evt = bus.trace_en & bus.reg_write & (bus.write_reg != 5'd0);
`ifdef TRACE_MEM_ENABLE_EN
    assign w_mem_evt    = bus.trace_en & bus.mem_write;
    assign w_unused_mem = ^bus.mem_addr[31:16];
`else
    assign w_mem_evt    = 1'b0;
    assign w_unused_mem = ^{bus.mem_write, bus.mem_addr, bus.mem_wdata};
`endif
    assign w_evt_n = {1'b0, w_reg_evt} + {1'b0, w_mem_evt};
    assign w_pop   = w_valid & bus.out_ready;
    assign w_free  = ~w_full | w_pop;

    // Once anything is lost, every event is counted until the marker gets a slot.
    always_comb begin
        w_push         = 1'b0;
        w_drop         = 1'b0;
        w_marker_nxt   = r_marker_pending;
        w_drop_cnt_nxt = r_drop_cnt;
        w_entry        = '0;
        w_entry.stamp  = r_cycle;
        if (r_marker_pending) begin
            if (w_free) begin
                w_push         = 1'b1;
                w_entry.kind   = TRACE_KIND_DROP;
                w_entry.value  = {{(VALUE_W-DROP_CNT_W){1'b0}}, sat_add(r_drop_cnt, w_evt_n)};
                w_drop_cnt_nxt = '0;
                w_marker_nxt   = 1'b0;
            end else begin
                w_drop_cnt_nxt = sat_add(r_drop_cnt, w_evt_n);
            end
        end else if (w_reg_evt) begin
            if (w_free) begin
                w_push        = 1'b1;
                w_entry.kind  = TRACE_KIND_REG;
                w_entry.tag   = {11'b0, bus.write_reg};
                w_entry.value = bus.write_data;
                w_drop        = w_mem_evt;
            end else begin
                w_drop = 1'b1;
            end
            if (w_drop) w_drop_cnt_nxt = sat_add(r_drop_cnt, w_free ? 2'd1 : w_evt_n);
        end else if (w_mem_evt) begin
            if (w_free) begin
                w_push        = 1'b1;
                w_entry.kind  = TRACE_KIND_MEM;
                w_entry.tag   = bus.mem_addr[15:0];
                w_entry.value = bus.mem_wdata;
            end else begin
                w_drop         = 1'b1;
                w_drop_cnt_nxt = sat_add(r_drop_cnt, 2'd1);
            end
        end
        if (w_drop) w_marker_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle          <= '0;
            r_drop_cnt       <= '0;
            r_marker_pending <= 1'b0;
            r_overflow_seen  <= 1'b0;
        end else begin
            r_cycle          <= r_cycle + 1'b1;
            r_drop_cnt       <= w_drop_cnt_nxt;
            r_marker_pending <= w_marker_nxt;
            if (w_drop) r_overflow_seen <= 1'b1;
        end
    end

    trace_fifo #(.DEPTH(DEPTH), .W(TRACE_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_entry),
        .o_rdata (bus.out_data),
        .o_valid (w_valid),
        .o_full  (w_full),
        .o_level (bus.fifo_level)
    );

    assign bus.out_valid     = w_valid;
    assign bus.overflow_seen = r_overflow_seen;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Bench for mips_trace_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_mips_trace_buffer;

    localparam int DEPTH = 16;
`ifdef TRACE_MEM_ENABLE_EN
    localparam bit MEM_ON = 1'b1;
`else
    localparam bit MEM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_trace_buffer_if #(.DEPTH(DEPTH)) bus ();
    mips_trace_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [63:0] q[$];
    int unsigned m_cycle;
    int unsigned m_drops;
    bit          m_pend;
    bit          m_ovf;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int unsigned sat16(input int unsigned x);
        return (x > 65535) ? 65535 : x;
    endfunction

    // Model of what the edge about to happen does, from the current inputs.
    task automatic model_edge();
        logic [63:0] ev[$];
        if (rst) begin
            q.delete();
            m_cycle = 0; m_drops = 0; m_pend = 0; m_ovf = 0;
            return;
        end
        if (bus.trace_en && bus.reg_write && bus.write_reg != 5'd0)
            ev.push_back({2'b01, 14'(m_cycle), 11'd0, bus.write_reg, bus.write_data});
        if (MEM_ON && bus.trace_en && bus.mem_write)
            ev.push_back({2'b10, 14'(m_cycle), bus.mem_addr[15:0], bus.mem_wdata});
        if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
        if (m_pend) begin
            if (q.size() < DEPTH) begin
                q.push_back({2'b11, 14'(m_cycle), 16'd0, 32'(sat16(m_drops + ev.size()))});
                m_drops = 0;
                m_pend  = 0;
            end else begin
                m_drops = sat16(m_drops + ev.size());
            end
        end else begin
            foreach (ev[i]) begin
                if (i == 0 && q.size() < DEPTH) q.push_back(ev[i]);
                else begin
                    m_drops = sat16(m_drops + 1);
                    m_pend  = 1;
                    m_ovf   = 1;
                end
            end
        end
        m_cycle = (m_cycle + 1) % 16384;
    endtask

    task automatic check_outputs();
        check_eq("valid", 64'(bus.out_valid), 64'(q.size() > 0));
        check_eq("data", bus.out_data, (q.size() > 0) ? q[0] : 64'd0);
        check_eq("level", 64'(bus.fifo_level), 64'(q.size()));
        check_eq("ovf", 64'(bus.overflow_seen), 64'(m_ovf));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_idle();
        bus.trace_en   = 1'b1;
        bus.reg_write  = 1'b0;
        bus.write_reg  = 5'd0;
        bus.write_data = 32'd0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = 32'd0;
        bus.mem_wdata  = 32'd0;
        bus.out_ready  = 1'b0;
    endtask

    task automatic reg_ev(input logic [4:0] r, input logic [31:0] d);
        bus.reg_write  = 1'b1;
        bus.write_reg  = r;
        bus.write_data = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] last;
        logic [63:0] exp_mem;
        int          guard;
        int          ready_pct;

        rst = 1'b1;
        set_idle();
        @(negedge clk);
        step();
        step();
        check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_data", bus.out_data, 64'd0);
        check_eq("rst_level", 64'(bus.fifo_level), 64'd0);
        check_eq("rst_ovf", 64'(bus.overflow_seen), 64'd0);
        rst = 1'b0;

        repeat (5) step();
        reg_ev(5'd3, 32'h0000_0FFF);
        step();
        set_idle();
        check_eq("reg_first_data", bus.out_data, 64'h4005_0003_0000_0FFF);
        check_eq("reg_first_level", 64'(bus.fifo_level), 64'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_eq("pop_level", 64'(bus.fifo_level), 64'd0);

        reg_ev(5'd0, 32'h1234_5678);
        step();
        check_eq("r0_level", 64'(bus.fifo_level), 64'd0);
        bus.trace_en = 1'b0;
        reg_ev(5'd7, 32'h55);
        step();
        set_idle();
        check_eq("dis_level", 64'(bus.fifo_level), 64'd0);
        check_eq("dis_ovf", 64'(bus.overflow_seen), 64'd0);

        exp_mem = MEM_ON ? {2'b10, 14'(m_cycle), 16'h0015, 32'hDEAD_BEEF} : 64'd0;
        bus.mem_write = 1'b1;
        bus.mem_addr  = 32'h0000_0015;
        bus.mem_wdata = 32'hDEAD_BEEF;
        step();
        set_idle();
        check_eq("mem_data", bus.out_data, exp_mem);
        bus.out_ready = 1'b1;
        step();
        set_idle();

        repeat (DEPTH + 3) begin
            reg_ev(5'($urandom_range(1, 31)), $urandom);
            step();
        end
        set_idle();
        check_eq("fill_level", 64'(bus.fifo_level), 64'(DEPTH));
        check_eq("fill_ovf", 64'(bus.overflow_seen), 64'd1);
        bus.out_ready = 1'b1;
        step();
        check_eq("marker_level", 64'(bus.fifo_level), 64'(DEPTH));
        last  = '0;
        guard = 0;
        while (bus.out_valid && guard < 4 * DEPTH) begin
            last = bus.out_data;
            step();
            guard++;
        end
        check_eq("drain_bound", 64'(bus.out_valid), 64'd0);
        check_eq("drop_kind", 64'(last[63:62]), 64'd3);
        check_eq("drop_val", 64'(last[47:0]), 64'd3);
        set_idle();
        reg_ev(5'd5, 32'hABC);
        step();
        set_idle();
        check_eq("resume_kind", 64'(bus.out_data[63:62]), 64'd1);
        bus.out_ready = 1'b1;
        step();
        set_idle();

        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (DEPTH) begin
            reg_ev(5'($urandom_range(1, 31)), $urandom);
            step();
        end
        reg_ev(5'd9, 32'h99);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_eq("fullpop_level", 64'(bus.fifo_level), 64'(DEPTH));
        check_eq("fullpop_ovf", 64'(bus.overflow_seen), 64'd0);
        step();
        step();
        set_idle();
        check_eq("pend_ovf", 64'(bus.overflow_seen), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("midrst_level", 64'(bus.fifo_level), 64'd0);
        reg_ev(5'd9, 32'h1);
        step();
        set_idle();
        check_eq("midrst_stamp", 64'(bus.out_data[61:48]), 64'd0);

        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) ready_pct = (i % 200 == 0) ? 30 : 90;
            rst            = ($urandom_range(0, 149) == 0);
            bus.trace_en   = ($urandom_range(0, 7) != 0);
            bus.reg_write  = $urandom_range(0, 1) == 1;
            bus.write_reg  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.write_data = $urandom;
            bus.mem_write  = ($urandom_range(0, 3) == 0);
            bus.mem_addr   = $urandom;
            bus.mem_wdata  = $urandom;
            bus.out_ready  = ($urandom_range(0, 99) < ready_pct);
            step();
        end
        rst = 1'b0;
        set_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
